// File: rtl/pulse_train_gen.sv
// Moore pulse-train source: on start, emits `count` one-cycle pulses on x_out separated by
// `gap` low cycles, then a one-cycle done strobe, then returns to idle.
module pulse_train_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] count,
  input  logic [1:0] gap,
  output logic       x_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StFin} state_e;

  state_e     state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [1:0] gcnt_q, gcnt_d;
  logic [1:0] gap_l_q, gap_l_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    gap_l_d = gap_l_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (count != 3'd0) begin
            state_d = StPulse;
            rem_d   = count;
            gap_l_d = gap;
          end else begin
            state_d = StFin;
          end
        end
      end
      StPulse: begin
        rem_d = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          state_d = StFin;
        end else if (gap_l_q == 2'd0) begin
          state_d = StPulse;
        end else begin
          state_d = StGap;
          gcnt_d  = gap_l_q;
        end
      end
      StGap: begin
        gcnt_d = gcnt_q - 2'd1;
        if (gcnt_q == 2'd1) begin
          state_d = StPulse;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly (Moore).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= 3'd0;
      gcnt_q  <= 2'd0;
      gap_l_q <= 2'd0;
      x_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
      gap_l_q <= gap_l_d;
      x_out   <= (state_d == StPulse);
      busy    <= (state_d != StIdle);
      done    <= (state_d == StFin);
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed and random trains against a queue-based
// model of the expected {x_out, busy, done} stream.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] count = 3'd0;
  logic [1:0] gap = 2'd0;
  logic       x_out, busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int highs = 0;
  int trainlen = 0;

  // Expected {x_out, busy, done} for upcoming cycles, and for the current cycle.
  logic [2:0] q[$];
  logic [2:0] cur = 3'b000;

  localparam logic [2:0] OutIdle  = 3'b000;
  localparam logic [2:0] OutPulse = 3'b110;
  localparam logic [2:0] OutGap   = 3'b010;
  localparam logic [2:0] OutFin   = 3'b011;

  always #5 clk = ~clk;

  pulse_train_gen dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .gap   (gap),
    .x_out (x_out),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build(input int c, input int g);
    if (c == 0) begin
      q.push_back(OutFin);
    end else begin
      for (int i = 1; i <= c; i++) begin
        q.push_back(OutPulse);
        if (i < c) repeat (g) q.push_back(OutGap);
      end
      q.push_back(OutFin);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      cur = OutIdle;
    end else if (cur == OutIdle && start) begin
      build(int'(count), int'(gap));
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = OutIdle;
    end
    #1;
    check(tag, int'({x_out, busy, done}), int'(cur));
    if (x_out) highs++;
    if (busy && !done) trainlen++;
  endtask

  task automatic finish_train(input string tag, input bit noise);
    int guard = 0;
    while (cur != OutIdle && guard < 60) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        count = 3'($urandom_range(0, 7));
        gap   = 2'($urandom_range(0, 3));
      end
      step(tag);
      guard++;
    end
    if (guard >= 60) check({tag, "_timeout"}, guard, 0);
    start = 1'b0;
  endtask

  task automatic run_train(input string tag, input int c, input int g, input bit noise);
    highs = 0;
    trainlen = 0;
    start = 1'b1;
    count = 3'(c);
    gap   = 2'(g);
    step(tag);
    start = 1'b0;
    finish_train(tag, noise);
  endtask

  initial begin
    // Reset held with start asserted: nothing may begin.
    rst = 1'b0; start = 1'b1; count = 3'd3;
    step("reset0");
    step("reset1");
    rst = 1'b1; start = 1'b0;
    step("idle");

    run_train("basic_3_0", 3, 0, 1'b0);
    check("basic_highs", highs, 3);
    step("basic_after");

    run_train("gapped_2_2", 2, 2, 1'b0);
    check("gapped_ones", highs, 2);
    check("gapped_len", trainlen, 4);
    step("gapped_after");

    run_train("count0", 0, 2, 1'b0);
    check("count0_highs", highs, 0);
    step("count0_after");

    run_train("max_7_3", 7, 3, 1'b0);
    check("max_highs", highs, 7);
    check("max_len", trainlen, 25);
    step("max_after");

    // Start held high (different count) through GAP and FIN must be ignored.
    highs = 0;
    start = 1'b1; count = 3'd4; gap = 2'd2;
    step("busy_start");
    count = 3'd6;
    while (cur != OutFin && trainlen < 100) step("busy_hold");
    check("busy_reached_fin", int'(cur), int'(OutFin));
    step("busy_fin_edge");
    start = 1'b0;
    step("busy_idle");
    check("busy_highs", highs, 4);

    // Reset during the second pulse of a 5-pulse train.
    highs = 0;
    start = 1'b1; count = 3'd5; gap = 2'd1;
    step("abort_p1");
    start = 1'b0;
    step("abort_g1");
    step("abort_p2");
    rst = 1'b0;
    step("abort_rst");
    check("abort_highs", highs, 2);
    rst = 1'b1;
    step("abort_idle");
    run_train("abort_fresh", 5, 1, 1'b0);
    check("fresh_highs", highs, 5);
    step("fresh_after");

    for (int t = 0; t < 25; t++) begin
      int c = $urandom_range(0, 7);
      int g = $urandom_range(0, 3);
      run_train("rand", c, g, 1'b1);
      check("rand_highs", highs, c);
      repeat ($urandom_range(1, 3)) step("rand_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
